// File: rtl/bsg_cache_nb_mhu_way_alloc.sv
// bsg_cache_nb_mhu_way_alloc
//
// Way-allocation sequencer for the non-blocking cache miss handling unit.
// It takes one tag miss at a time and reads the tag/stat state of the missed
// set. It presents the set index to the external way chooser and consumes the
// chosen way. If the chooser reports that no way is available, it backs off
// and re-reads the set. Otherwise it reserves the way by setting its
// waiting_for_fill_data stat bit, then issues one fill (plus optional evict)
// request to the DMA queue.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   miss_*                  incoming miss request (valid/ready, index, tag)
//   rd_*                    tag/stat read request; grant on rd_ready_i
//   valid_i/dirty_i/tag_i   per-way set state, one cycle after the read grant
//   chooser_index_o         index presented to the way chooser
//   chosen_way_i            way selected by the chooser
//   no_available_way_i      chooser reports that no way is available
//   stat_w_*                reserve-way stat write (valid/ready, index, way)
//   dma_*                   fill/evict request to the DMA queue
//   busy_o                  sequencer is not idle
//   retry_count_o           saturating count of failed choices for this miss
module bsg_cache_nb_mhu_way_alloc #(
    parameter int sets_p       = 16,
    parameter int ways_p       = 4,
    parameter int tag_width_p  = 8,
    parameter int retry_wait_p = 4,
    localparam int lg_sets_lp  = (sets_p == 1) ? 1 : $clog2(sets_p),
    localparam int lg_ways_lp  = (ways_p == 1) ? 1 : $clog2(ways_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic                          miss_v_i,
    input  logic [lg_sets_lp-1:0]         miss_index_i,
    input  logic [tag_width_p-1:0]        miss_tag_i,
    output logic                          miss_ready_o,

    output logic                          rd_v_o,
    output logic [lg_sets_lp-1:0]         rd_index_o,
    input  logic                          rd_ready_i,

    input  logic [ways_p-1:0]             valid_i,
    input  logic [ways_p-1:0]             dirty_i,
    input  logic [ways_p*tag_width_p-1:0] tag_i,

    output logic [lg_sets_lp-1:0]         chooser_index_o,
    input  logic [lg_ways_lp-1:0]         chosen_way_i,
    input  logic                          no_available_way_i,

    output logic                          stat_w_v_o,
    output logic [lg_sets_lp-1:0]         stat_w_index_o,
    output logic [lg_ways_lp-1:0]         stat_w_way_o,
    input  logic                          stat_w_ready_i,

    output logic                          dma_v_o,
    output logic [lg_sets_lp-1:0]         dma_index_o,
    output logic [lg_ways_lp-1:0]         dma_way_o,
    output logic [tag_width_p-1:0]        dma_tag_o,
    output logic                          dma_evict_o,
    output logic [tag_width_p-1:0]        dma_evict_tag_o,
    input  logic                          dma_ready_i,

    output logic                          busy_o,
    output logic [7:0]                    retry_count_o
);

    localparam int cnt_width_lp = $clog2(retry_wait_p + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CHOOSE  = 3'd2,
        BACKOFF = 3'd3,
        COMMIT  = 3'd4,
        DMA     = 3'd5
    } state_e;

    state_e                  state_q;
    logic                    miss_ready_q;
    logic                    busy_q;
    logic                    rd_v_q;
    logic                    stat_w_v_q;
    logic                    dma_v_q;
    logic [lg_sets_lp-1:0]   index_q;
    logic [tag_width_p-1:0]  tag_q;
    logic [lg_ways_lp-1:0]   way_q;
    logic                    evict_q;
    logic [tag_width_p-1:0]  evict_tag_q;
    logic [7:0]              retry_q;
    logic [cnt_width_lp-1:0] backoff_q;

    logic [7:0]              retry_d;
    logic [tag_width_p-1:0]  victim_tag_d;
    logic                    victim_evict_d;

    // Saturating increment of the failed-choice counter.
    always_comb begin
        retry_d = (retry_q == 8'hFF) ? retry_q : (retry_q + 8'd1);
    end

    // Victim selection: OR-reduce the chosen way's fields so that ways_p
    // values that are not a power of two never index out of range.
    always_comb begin
        victim_tag_d   = '0;
        victim_evict_d = 1'b0;
        for (int w = 0; w < ways_p; w++) begin
            victim_tag_d   = victim_tag_d
                           | ({tag_width_p{chosen_way_i == lg_ways_lp'(w)}}
                              & tag_i[w*tag_width_p +: tag_width_p]);
            victim_evict_d = victim_evict_d
                           | ((chosen_way_i == lg_ways_lp'(w)) & valid_i[w] & dirty_i[w]);
        end
    end

    // Sequencer FSM; every valid/ready flag is a register updated with the state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            miss_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            rd_v_q       <= 1'b0;
            stat_w_v_q   <= 1'b0;
            dma_v_q      <= 1'b0;
            index_q      <= '0;
            tag_q        <= '0;
            way_q        <= '0;
            evict_q      <= 1'b0;
            evict_tag_q  <= '0;
            retry_q      <= 8'd0;
            backoff_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_v_i) begin
                        index_q      <= miss_index_i;
                        tag_q        <= miss_tag_i;
                        retry_q      <= 8'd0;
                        miss_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        rd_v_q       <= 1'b1;
                        state_q      <= READ;
                    end
                end
                READ: begin
                    if (rd_ready_i) begin
                        rd_v_q  <= 1'b0;
                        state_q <= CHOOSE;
                    end
                end
                CHOOSE: begin
                    // Read data for the granted set is present only in this cycle.
                    if (no_available_way_i) begin
                        retry_q   <= retry_d;
                        backoff_q <= cnt_width_lp'(retry_wait_p);
                        state_q   <= BACKOFF;
                    end else begin
                        way_q       <= chosen_way_i;
                        evict_q     <= victim_evict_d;
                        evict_tag_q <= victim_tag_d;
                        stat_w_v_q  <= 1'b1;
                        state_q     <= COMMIT;
                    end
                end
                BACKOFF: begin
                    // The last wait cycle is the one where the counter hits zero;
                    // the set is always re-read because its state may have moved.
                    backoff_q <= backoff_q - cnt_width_lp'(1);
                    if (backoff_q == cnt_width_lp'(1)) begin
                        rd_v_q  <= 1'b1;
                        state_q <= READ;
                    end
                end
                COMMIT: begin
                    if (stat_w_ready_i) begin
                        stat_w_v_q <= 1'b0;
                        dma_v_q    <= 1'b1;
                        state_q    <= DMA;
                    end
                end
                DMA: begin
                    if (dma_ready_i) begin
                        dma_v_q      <= 1'b0;
                        busy_q       <= 1'b0;
                        miss_ready_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    miss_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    rd_v_q       <= 1'b0;
                    stat_w_v_q   <= 1'b0;
                    dma_v_q      <= 1'b0;
                end
            endcase
        end
    end

    // Handshake flags are forced low while reset is held, including the
    // first reset cycle before the reset edge has been taken.
    assign miss_ready_o    = miss_ready_q & ~reset_i;
    assign busy_o          = busy_q & ~reset_i;
    assign rd_v_o          = rd_v_q & ~reset_i;
    assign stat_w_v_o      = stat_w_v_q & ~reset_i;
    assign dma_v_o         = dma_v_q & ~reset_i;

    assign rd_index_o      = index_q;
    assign chooser_index_o = index_q;
    assign stat_w_index_o  = index_q;
    assign stat_w_way_o    = way_q;
    assign dma_index_o     = index_q;
    assign dma_way_o       = way_q;
    assign dma_tag_o       = tag_q;
    assign dma_evict_o     = evict_q;
    assign dma_evict_tag_o = evict_tag_q;
    assign retry_count_o   = retry_q;

endmodule
